// File: rtl/weight_cache_db_pkg.sv
// Shared defaults and loader-state encoding for the double-buffered weight cache.
package weight_cache_db_pkg;

  localparam int LANES_DEF  = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 1024;
  localparam int DIM_W_DEF  = 16;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_FILL = 2'd1,
    L_DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/weight_cache_db_bank_ram.sv
// One weight bank: simple dual-port RAM, one write port and one registered read port.
module wc_bank_ram
  import weight_cache_db_pkg::*;
#(
  parameter int WIDTH = LANES_DEF * DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage and read register carry no reset so the array maps onto block RAM;
  // consumers qualify rdata with their own valid flag.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/weight_cache_db.sv
// Double-buffered weight cache: one bank is filled from the stream while the other
// feeds the systolic array one row of LANES weights per read request.
module weight_cache_db
  import weight_cache_db_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIM_W-1:0]        matrix_row,
  input  logic [DIM_W-1:0]        matrix_col,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DATA_W-1:0] s_data,
  input  logic                    rd_valid,
  input  logic                    layer_end,
  output logic                    m_valid,
  output logic [LANES*DATA_W-1:0] m_data,
  output logic [LANES-1:0]        col_switch,
  output logic                    weight_cached,
  output logic                    cfg_err
);

  localparam int W  = LANES * DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int W2 = 2 * DIM_W;

  loader_state_e    state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             act_q;
  logic [W2-1:0]    req_groups, req_words;
  logic             start_ok, launch, accept, last_word, handover, rd_en;

  logic [DIM_W-1:0] fill_row_q, fill_col_q, fill_groups_q;
  logic [W2-1:0]    fill_words_q;
  logic [AW-1:0]    widx_q;
  logic [DIM_W-1:0] act_row_q, act_col_q, act_groups_q;
  logic [DIM_W-1:0] row_q, grp_q;
  logic [AW-1:0]    rd_addr_q;

  logic             last_grp, row_wrap;
  logic [DIM_W-1:0] last_rem;
  logic [LANES-1:0] lane_mask;
  logic             m_valid_q, rd_bank_q;
  logic [LANES-1:0] col_switch_q;
  logic [W-1:0]     bank_rdata [2];

  // Full-width size math so an oversize request cannot alias to a small word count.
  always_comb begin
    req_groups = (W2'(matrix_col) + W2'(LANES - 1)) / W2'(LANES);
    req_words  = W2'(matrix_row) * req_groups;
    start_ok   = (req_words != '0) && (req_words <= W2'(DEPTH));
  end

  assign s_ready   = (state_q == L_FILL);
  assign accept    = s_valid && s_ready;
  assign last_word = accept && (W2'(widx_q) == fill_words_q - W2'(1));
  assign launch    = start && (state_q == L_IDLE) && start_ok && !full_q[~act_q];
  assign handover  = full_q[~act_q] && (!full_q[act_q] || layer_end);
  assign rd_en     = rd_valid && full_q[act_q];

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      L_IDLE:  if (launch)    state_d = L_FILL;
      L_FILL:  if (last_word) state_d = L_DONE;
      L_DONE:  if (handover)  state_d = L_IDLE;
      default:                state_d = L_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (last_word) full_d[~act_q] = 1'b1;
    if (layer_end) full_d[act_q]  = 1'b0;
  end

  always_comb begin
    last_grp = (grp_q == act_groups_q - DIM_W'(1));
    row_wrap = (row_q == act_row_q - DIM_W'(1));
    last_rem = act_col_q % DIM_W'(LANES);
    lane_mask = '0;
    for (int i = 0; i < LANES; i++)
      lane_mask[i] = !last_grp || (last_rem == '0) || (DIM_W'(i) < last_rem);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= L_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q        <= '0;
      act_q         <= 1'b0;
      cfg_err       <= 1'b0;
      fill_row_q    <= '0;
      fill_col_q    <= '0;
      fill_groups_q <= '0;
      fill_words_q  <= '0;
      widx_q        <= '0;
      act_row_q     <= '0;
      act_col_q     <= '0;
      act_groups_q  <= '0;
      row_q         <= '0;
      grp_q         <= '0;
      rd_addr_q     <= '0;
      m_valid_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      col_switch_q  <= '0;
    end else begin
      full_q <= full_d;
      if (start && state_q == L_IDLE) cfg_err <= !start_ok;

      if (launch) begin
        fill_row_q    <= matrix_row;
        fill_col_q    <= matrix_col;
        fill_groups_q <= DIM_W'(req_groups);
        fill_words_q  <= req_words;
        widx_q        <= '0;
      end else if (accept) begin
        widx_q <= widx_q + AW'(1);
      end

      // Handover wins over read advance: the new bank always starts at row 0, group 0.
      if (handover) begin
        act_q        <= ~act_q;
        act_row_q    <= fill_row_q;
        act_col_q    <= fill_col_q;
        act_groups_q <= fill_groups_q;
        row_q        <= '0;
        grp_q        <= '0;
        rd_addr_q    <= '0;
      end else if (rd_en) begin
        if (row_wrap) begin
          row_q <= '0;
          grp_q <= last_grp ? '0 : grp_q + DIM_W'(1);
        end else begin
          row_q <= row_q + DIM_W'(1);
        end
        rd_addr_q <= (row_wrap && last_grp) ? '0 : rd_addr_q + AW'(1);
      end

      m_valid_q    <= rd_en;
      rd_bank_q    <= act_q;
      col_switch_q <= rd_en ? lane_mask : '0;
    end
  end

  wc_bank_ram #(.WIDTH(W), .DEPTH(DEPTH)) u_bank0 (
    .clk   (clk),
    .we    (accept && act_q),
    .waddr (widx_q),
    .wdata (s_data),
    .re    (rd_en && !act_q),
    .raddr (rd_addr_q),
    .rdata (bank_rdata[0])
  );

  wc_bank_ram #(.WIDTH(W), .DEPTH(DEPTH)) u_bank1 (
    .clk   (clk),
    .we    (accept && !act_q),
    .waddr (widx_q),
    .wdata (s_data),
    .re    (rd_en && act_q),
    .raddr (rd_addr_q),
    .rdata (bank_rdata[1])
  );

  assign m_valid       = m_valid_q;
  assign m_data        = m_valid_q ? bank_rdata[rd_bank_q] : '0;
  assign col_switch    = col_switch_q;
  assign weight_cached = full_q[act_q];

endmodule

// File: tb/tb_weight_cache_db.sv
// Directed bench for weight_cache_db: load/read/handover, partial last group, config errors, reset mid-load.
module tb_weight_cache_db;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, rd_valid, layer_end;
  logic [15:0] matrix_row, matrix_col;
  logic        s_ready, m_valid, weight_cached, cfg_err;
  logic [63:0] s_data, m_data;
  logic [7:0]  col_switch;

  int passed = 0;
  int total  = 0;

  weight_cache_db dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .matrix_row    (matrix_row),
    .matrix_col    (matrix_col),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .rd_valid      (rd_valid),
    .layer_end     (layer_end),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .col_switch    (col_switch),
    .weight_cached (weight_cached),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_start(input logic [15:0] r, input logic [15:0] c);
    matrix_row = r;
    matrix_col = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    int cnt = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt == 50) check("push_timeout", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_cached(input string tag);
    int cnt = 0;
    while (!weight_cached && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, 64'(weight_cached), 64'd1);
  endtask

  // One read request; the row must be presented exactly one cycle later.
  task automatic rd(input string tag, input logic rel, input logic [63:0] exp_d,
                    input logic [7:0] exp_m);
    rd_valid  = 1'b1;
    layer_end = rel;
    @(negedge clk);
    rd_valid  = 1'b0;
    layer_end = 1'b0;
    check({tag, "_valid"}, 64'(m_valid), 64'd1);
    check({tag, "_data"}, m_data, exp_d);
    check({tag, "_mask"}, 64'(col_switch), 64'(exp_m));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; rd_valid = 1'b0; layer_end = 1'b0;
    matrix_row = '0; matrix_col = '0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_col_switch", 64'(col_switch), 64'd0);
    check("rst_cached", 64'(weight_cached), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read with nothing cached: no output, pointers stay put.
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    check("empty_rd_valid", 64'(m_valid), 64'd0);
    check("empty_rd_mask", 64'(col_switch), 64'd0);

    // 4x8: one group of four rows.
    do_start(16'd4, 16'd8);
    check("ld1_s_ready", 64'(s_ready), 64'd1);
    for (int k = 1; k <= 4; k++) push(64'(k));
    wait_cached("ld1_cached");
    rd("ld1_r0", 1'b0, 64'h01, 8'hFF);
    rd("ld1_r1", 1'b0, 64'h02, 8'hFF);
    rd("ld1_r2", 1'b0, 64'h03, 8'hFF);
    rd("ld1_r3", 1'b0, 64'h04, 8'hFF);
    layer_end = 1'b1;
    @(negedge clk);
    layer_end = 1'b0;
    check("ld1_released", 64'(weight_cached), 64'd0);

    // 3x11: two groups, last group has 3 live lanes, then wrap to word 0.
    do_start(16'd3, 16'd11);
    for (int k = 0; k < 6; k++) push(64'h11 + 64'(k));
    wait_cached("ld2_cached");
    rd("ld2_g0r0", 1'b0, 64'h11, 8'hFF);
    rd("ld2_g0r1", 1'b0, 64'h12, 8'hFF);
    rd("ld2_g0r2", 1'b0, 64'h13, 8'hFF);
    rd("ld2_g1r0", 1'b0, 64'h14, 8'h07);
    rd("ld2_g1r1", 1'b0, 64'h15, 8'h07);
    rd("ld2_g1r2", 1'b0, 64'h16, 8'h07);
    rd("ld2_wrap", 1'b0, 64'h11, 8'hFF);

    // Load B while A is active: B parks in L_DONE until A is released.
    do_start(16'd2, 16'd8);
    push(64'h21);
    push(64'h22);
    repeat (2) @(negedge clk);
    check("ldB_parked_s_ready", 64'(s_ready), 64'd0);
    check("ldB_A_cached", 64'(weight_cached), 64'd1);
    rd("ldB_A_r1", 1'b0, 64'h12, 8'hFF);
    rd("ldB_A_last_rel", 1'b1, 64'h13, 8'hFF);
    check("ldB_cached", 64'(weight_cached), 64'd1);
    rd("ldB_r0", 1'b0, 64'h21, 8'hFF);
    rd("ldB_r1", 1'b0, 64'h22, 8'hFF);

    // Config errors: oversize, zero dims, exact-DEPTH accepted, start during fill ignored.
    do_start(16'd200, 16'd48);
    check("cfg_oversize_err", 64'(cfg_err), 64'd1);
    check("cfg_oversize_s_ready", 64'(s_ready), 64'd0);
    do_start(16'd0, 16'd8);
    check("cfg_zero_err", 64'(cfg_err), 64'd1);
    do_start(16'd128, 16'd64);
    check("cfg_depth_err_clr", 64'(cfg_err), 64'd0);
    check("cfg_depth_s_ready", 64'(s_ready), 64'd1);
    do_start(16'd200, 16'd48);
    check("cfg_ignored_in_fill", 64'(cfg_err), 64'd0);

    // Reset after two of the words.
    push(64'h41);
    push(64'h42);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_cached", 64'(weight_cached), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_start(16'd4, 16'd8);
    for (int k = 0; k < 4; k++) push(64'h31 + 64'(k));
    wait_cached("reload_cached");
    rd("reload_r0", 1'b0, 64'h31, 8'hFF);
    rd("reload_r1", 1'b0, 64'h32, 8'hFF);
    rd("reload_r2", 1'b0, 64'h33, 8'hFF);
    rd("reload_r3", 1'b0, 64'h34, 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/weight_cache_db.md
WEIGHT_CACHE_DB -- requirements
Module: weight_cache_db

Interface
REQ-001 Parameter LANES, default 8, systolic columns fed per cycle.
REQ-002 Parameter DATA_W, default 8, bits per weight element.
REQ-003 Parameter DEPTH, default 1024, words per bank; power of two.
REQ-004 Parameter DIM_W, default 16, width of matrix_row/matrix_col.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle pulse; begin loading one weight matrix.
REQ-008 matrix_row  input  DIM_W  K dimension (rows per column group); sampled on start.
REQ-009 matrix_col  input  DIM_W  output channels; sampled on start.
REQ-010 s_valid / s_ready / s_data  input / output / LANES*DATA_W  weight stream handshake.
REQ-011 rd_valid  input  1  consumer requests next weight row.
REQ-012 layer_end  input  1  pulse; consumer finished with active bank.
REQ-013 m_valid / m_data  output / output  1 / LANES*DATA_W  weight row to array.
REQ-014 col_switch  output  LANES  per-lane valid mask, aligned with m_data.
REQ-015 weight_cached  output  1  active bank holds a complete matrix.
REQ-016 cfg_err  output  1  sticky; last start rejected (oversize or zero dims).

Function
REQ-017 groups = ceil(matrix_col/LANES); words = matrix_row*groups, computed at DIM_W*2 width without truncation.
REQ-018 start with words==0 or words>DEPTH SHALL set cfg_err, leave loader state unchanged; valid start clears cfg_err.
REQ-019 Loader FSM: L_IDLE -> L_FILL on valid start when fill bank is empty; L_FILL -> L_DONE on accepted word index words-1; L_DONE -> L_IDLE when fill bank is handed over.
REQ-020 start arriving in L_FILL or L_DONE SHALL be ignored (no cfg_err).
REQ-021 s_ready SHALL be 1 only in L_FILL; word n accepted (s_valid&&s_ready) written to fill-bank address n.
REQ-022 Two banks, full flags full[1:0]; active pointer act, fill bank = !act.
REQ-023 Handover: when fill bank complete and active bank empty (or released same cycle by layer_end), act toggles next cycle; dims copied into active-side registers.
REQ-024 layer_end clears full[act]; ignored when weight_cached=0.
REQ-025 weight_cached = full[act].
REQ-026 Read: on rd_valid && weight_cached, address = grp*matrix_row + row; m_data, m_valid, col_switch valid exactly 1 cycle later.
REQ-027 row increments per rd_valid; at matrix_row-1 wraps to 0 and grp increments; grp wraps to 0 after groups-1.
REQ-028 col_switch = all ones except in last group, where lanes >= (matrix_col mod LANES) are 0 (all ones if remainder 0).
REQ-029 rd_valid with weight_cached=0 SHALL produce m_valid=0 and not advance row/grp.
REQ-030 row and grp SHALL reset to 0 on every handover.
REQ-031 layer_end and rd_valid same cycle: read served from current bank, then released.

Reset
REQ-032 rst SHALL clear full[], act=0, loader to L_IDLE, row/grp=0, cfg_err=0, dims=0.
REQ-033 Outputs at reset: s_ready=0, m_valid=0, m_data=0, col_switch=0, weight_cached=0.
REQ-034 rst mid-load SHALL discard partial data; next start begins at address 0.
REQ-035 Memory contents not reset.

Structure
REQ-036 Shared package holds LANES/DATA_W/DEPTH/DIM_W defaults and loader-state enum.
REQ-037 One sub-module, wc_bank_ram: simple dual-port RAM, 1 write, 1 registered read, instantiated twice.

Verification
REQ-038 Load row=4,col=8 (4 words 0x01..0x04), then 4 rd_valid -> m_data 0x01..0x04 one cycle after each, col_switch=0xFF, weight_cached=1.
REQ-039 row=3,col=11 (6 words) -> read order grp0 rows0-2 then grp1 rows0-2; col_switch 0xFF then 0x07; 7th read returns word 0.
REQ-040 Load A, then load B while reading A -> B in L_DONE, s_ready=0; layer_end -> next cycle act toggles, reads return B word 0.
REQ-041 start with row=200,col=48 (1200>1024) -> cfg_err=1, s_ready stays 0; later valid start clears cfg_err.
REQ-042 rst asserted after 2 of 4 words -> s_ready=0, weight_cached=0; fresh load of 4 words reads back correctly.
REQ-043 rd_valid with no bank loaded -> m_valid=0, subsequent first read after load returns word 0.
